// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} one quotient bit per cycle; EX stalls on
// start_i until ready_o. A zero divisor yields an all-zero result.
module div_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   div_q, div_d;
    logic                sdiv_q, sdiv_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W:0]     shifted_rem;
    logic [DATA_W:0]     diff;
    logic                take;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W-1:0]   q_fix;
    logic [DATA_W-1:0]   r_fix;

    // Datapath helpers: operand magnitudes, one restoring step, sign fixup.
    always_comb begin
        abs_a       = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        abs_b       = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        shifted_rem = {rem_q, quo_q[DATA_W-1]};
        take        = (shifted_rem >= {1'b0, div_q});
        diff        = shifted_rem - {1'b0, div_q};
        q_fix       = (sdiv_q && (neg_a_q ^ neg_b_q)) ? -quo_q : quo_q;
        r_fix       = (sdiv_q && neg_a_q) ? -rem_q : rem_q;
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        sdiv_d   = sdiv_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            ST_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    sdiv_d  = signed_div_i;
                    neg_a_d = signed_div_i & opdata1_i[DATA_W-1];
                    neg_b_d = signed_div_i & opdata2_i[DATA_W-1];
                    quo_d   = abs_a;
                    div_d   = abs_b;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: begin
                result_d = '0;
                state_d  = ST_END;
            end
            ST_ON: begin
                if (annul_i || !start_i) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    // quo_q doubles as the dividend shift register; its MSB
                    // feeds the remainder while quotient bits enter at the LSB.
                    if (take) begin
                        rem_d = diff[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = shifted_rem[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {r_fix, q_fix};
                    state_d  = ST_END;
                end
            end
            ST_END: begin
                if (!start_i) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            sdiv_q   <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            sdiv_q   <= sdiv_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks;
    int failures;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch an operation (edge N is the first posedge with start_i high),
    // scramble operands afterwards, and count edges until ready_o is seen.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        opdata1_i    = 32'hDEADBEEF;
        opdata2_i    = 32'h0;
        signed_div_i = ~s;
        lat = 0;
        res = '0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_o) begin
                res = result_o;
                break;
            end
        end
        if (!ready_o) lat = -1;
    endtask

    task automatic drop_start();
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL reset_state: ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_divu_basic();
        int lat;
        logic [63:0] res;
        do_op(1'b0, 32'd100, 32'd7, lat, res);
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL divu_100_7_latency: got %0d expected 34", lat);
        end
        checks++;
        if (res !== {32'd2, 32'd14}) begin
            failures++;
            $display("FAIL divu_100_7_result: got %h expected %h", res, {32'd2, 32'd14});
        end
        drop_start();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL divu_drop_start: ready=%b result=%h expected 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_signed();
        int lat;
        logic [63:0] res;
        do_op(1'b1, 32'hFFFFFFF9, 32'h2, lat, res);
        checks++;
        if (lat !== 34 || res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
            failures++;
            $display("FAIL div_m7_2: lat=%0d res=%h expected lat=34 res=%h", lat, res, {32'hFFFFFFFF, 32'hFFFFFFFD});
        end
        drop_start();
        do_op(1'b0, 32'hFFFFFFF9, 32'h2, lat, res);
        checks++;
        if (res !== {32'h1, 32'h7FFFFFFC}) begin
            failures++;
            $display("FAIL divu_fff9_2: got %h expected %h", res, {32'h1, 32'h7FFFFFFC});
        end
        drop_start();
        do_op(1'b1, 32'd7, 32'hFFFFFFFE, lat, res);
        checks++;
        if (res !== {32'h1, 32'hFFFFFFFD}) begin
            failures++;
            $display("FAIL div_7_m2: got %h expected %h", res, {32'h1, 32'hFFFFFFFD});
        end
        drop_start();
    endtask

    task automatic test_zero_divisor();
        int lat;
        logic [63:0] res;
        for (int m = 0; m < 2; m++) begin
            do_op(m[0], 32'd5, 32'd0, lat, res);
            checks++;
            if (lat !== 2 || res !== 64'h0) begin
                failures++;
                $display("FAIL zero_div_mode%0d: lat=%0d res=%h expected lat=2 res=0", m, lat, res);
            end
            drop_start();
        end
    endtask

    task automatic test_annul();
        int lat;
        logic [63:0] res;
        logic seen_ready;
        // annul together with start in FREE: request must be ignored
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd5;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL annul_in_free: ready=%b expected 0", ready_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        // annul at iteration 10 of a running 100/7
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        @(posedge clk);
        seen_ready = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ready_o) seen_ready = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        if (ready_o) seen_ready = 1'b1;
        checks++;
        if (seen_ready !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL annul_mid_on: ready_seen=%b result=%h expected 0/0", seen_ready, result_o);
        end
        annul_i = 1'b0;
        do_op(1'b0, 32'd9, 32'd3, lat, res);
        checks++;
        if (lat !== 34 || res !== {32'd0, 32'd3}) begin
            failures++;
            $display("FAIL annul_restart_9_3: lat=%0d res=%h expected lat=34 res=%h", lat, res, {32'd0, 32'd3});
        end
        // annul_i is ignored in END
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1 || result_o !== {32'd0, 32'd3}) begin
            failures++;
            $display("FAIL annul_in_end: ready=%b result=%h expected 1/%h", ready_o, result_o, {32'd0, 32'd3});
        end
        @(negedge clk);
        annul_i = 1'b0;
        drop_start();
    endtask

    task automatic test_async_reset();
        int lat;
        logic [63:0] res;
        // reset while holding a finished result in END
        do_op(1'b0, 32'd100, 32'd7, lat, res);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL async_reset_end: ready=%b result=%h expected 0/0", ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b1;
        // reset at iteration 20 of a running operation
        start_i = 1'b0;
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL async_reset_on: ready=%b result=%h expected 0/0", ready_o, result_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_op(1'b0, 32'hFFFFFFFF, 32'd1, lat, res);
        checks++;
        if (lat !== 34 || res !== {32'd0, 32'hFFFFFFFF}) begin
            failures++;
            $display("FAIL after_reset_ffff_1: lat=%0d res=%h expected lat=34 res=%h", lat, res, {32'd0, 32'hFFFFFFFF});
        end
        drop_start();
    endtask

    task automatic test_corner_hold();
        int lat;
        logic [63:0] res;
        logic bad;
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
        checks++;
        if (lat !== 34 || res !== {32'h0, 32'h80000000}) begin
            failures++;
            $display("FAIL div_min_m1: lat=%0d res=%h expected lat=34 res=%h", lat, res, {32'h0, 32'h80000000});
        end
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b1 || result_o !== {32'h0, 32'h80000000}) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL end_hold: ready=%b result=%h expected 1/%h", ready_o, result_o, {32'h0, 32'h80000000});
        end
        drop_start();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [63:0] res;
        do_op(1'b0, 32'hFFFFFFFF, 32'h10, lat, res);
        checks++;
        if (lat !== 34 || res !== {32'hF, 32'h0FFFFFFF}) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d res=%h expected lat=34 res=%h", lat, res, {32'hF, 32'h0FFFFFFF});
        end
        drop_start();
        do_op(1'b0, 32'd1000, 32'd1000, lat, res);
        checks++;
        if (lat !== 34 || res !== {32'd0, 32'd1}) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d res=%h expected lat=34 res=%h", lat, res, {32'd0, 32'd1});
        end
        drop_start();
        do_op(1'b0, 32'd3, 32'hFFFFFFFF, lat, res);
        checks++;
        if (res !== {32'd3, 32'd0}) begin
            failures++;
            $display("FAIL b2b_small_by_big: got %h expected %h", res, {32'd3, 32'd0});
        end
        drop_start();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_zero_divisor();
        test_annul();
        test_async_reset();
        test_corner_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
